run_detect_ctrl: RTL and testbench

RUN_DETECT_CTRL -- requirements
Module: run_detect_ctrl

---
 rtl/run_detect_ctrl.sv | 169 ++++++++++++++++
 tb/tb_run_detect_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/run_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : run_detect_ctrl
//  Purpose  : Accepts a parallel word, serialises it MSB first and flags
//             every bit that completes a run of RUN_LEN consecutive ones.
//             The run count persists across words. hit_cnt keeps a
//             saturating tally of the hits.
//  Options  : RUN_RESTART_EN  - when defined, detection is non-overlapping
//                               (run count restarts after each hit);
//                               otherwise the count stays saturated and
//                               every further 1 bit is a hit.
//  Revision : 1.0  initial release
// ============================================================================
module run_detect_ctrl #(
  parameter int WORD_W  = 8,
  parameter int RUN_LEN = 4
) (
  input  logic              clk,
  input  logic              rst,       // asynchronous, active-low
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  input  logic              clr,
  output logic              z,
  output logic              done,
  output logic              busy,
  output logic [7:0]        hit_cnt
);

  localparam int c_CNT_W = $clog2(RUN_LEN + 1);
  localparam int c_IDX_W = (WORD_W > 2) ? $clog2(WORD_W) : 1;

  localparam logic [c_CNT_W-1:0] c_RUN_MAX  = c_CNT_W'(RUN_LEN);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WORD_W - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
  localparam logic [7:0]         c_HIT_MAX  = 8'hFF;
  localparam logic [7:0]         c_HIT_ONE  = 8'h01;

  // One-hot controller states
  typedef enum logic [2:0] {
    S_IDLE  = 3'b001,
    S_SHIFT = 3'b010,
    S_DONE  = 3'b100
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;

  logic [WORD_W-1:0]   r_shreg;
  logic [c_IDX_W-1:0]  r_idx;
  logic [c_CNT_W-1:0]  r_run;
  logic                r_z;
  logic [7:0]          r_hit_cnt;

  logic                w_load;
  logic                w_bit;
  logic [c_CNT_W-1:0]  w_run_upd;
  logic                w_hit;

  // State register; reset discards any word in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and Moore handshake/status outputs
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        busy = 1'b1;
        // index 0 is the last bit of the word
        if (r_idx == '0) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done        = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign w_load = in_ready & in_valid;
  assign w_bit  = r_shreg[WORD_W-1];

  // Shift register and bit index: load on handshake, shift out MSB first
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shreg <= '0;
      r_idx   <= '0;
    end else if (w_load) begin
      r_shreg <= in_data;
      r_idx   <= c_IDX_LAST;
    end else if (busy) begin
      r_shreg <= {r_shreg[WORD_W-2:0], 1'b0};
      if (r_idx != '0) begin
        r_idx <= r_idx - c_IDX_ONE;
      end
    end
  end

  // Post-update run count and hit decision for the bit being evaluated
  always_comb begin
    w_run_upd = r_run;
    w_hit     = 1'b0;
    if (busy) begin
      if (w_bit) begin
        if (r_run != c_RUN_MAX) begin
          w_run_upd = r_run + c_CNT_ONE;
        end else begin
          w_run_upd = c_RUN_MAX;
        end
      end else begin
        w_run_upd = '0;
      end
      w_hit = (w_run_upd == c_RUN_MAX);
`ifdef RUN_RESTART_EN
      // Non-overlapping: the next hit needs a full fresh run
      if (w_hit) begin
        w_run_upd = '0;
      end
`else
      // Overlapping: count stays saturated so each further 1 hits again
`endif
    end
  end

  // Run count, hit flag and hit tally; clear wins over any update
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_run     <= '0;
      r_z       <= 1'b0;
      r_hit_cnt <= '0;
    end else if (clr) begin
      r_run     <= '0;
      r_z       <= 1'b0;
      r_hit_cnt <= '0;
    end else begin
      r_run <= w_run_upd;
      r_z   <= w_hit;
      // Tally tracks z: it advances on the same edge that raises z
      if (w_hit && (r_hit_cnt != c_HIT_MAX)) begin
        r_hit_cnt <= r_hit_cnt + c_HIT_ONE;
      end
    end
  end

  assign z       = r_z;
  assign hit_cnt = r_hit_cnt;

endmodule
`default_nettype wire

// File: tb/tb_run_detect_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_run_detect_ctrl
//  Purpose  : Scoreboard bench for run_detect_ctrl (WORD_W=8, RUN_LEN=4).
//             The driver predicts each word's per-bit hit pattern and final
//             hit count from a bit-level model; the monitor collects z over
//             the word and compares when done pulses.
//  Revision : 1.0  initial release
// ============================================================================
module tb_run_detect_ctrl;

  localparam int WORD_W  = 8;
  localparam int RUN_LEN = 4;
`ifdef RUN_RESTART_EN
  localparam int FF_HITS = 2;
`else
  localparam int FF_HITS = 5;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       clr;
  logic       z;
  logic       done;
  logic       busy;
  logic [7:0] hit_cnt;

  run_detect_ctrl #(.WORD_W(WORD_W), .RUN_LEN(RUN_LEN)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .clr      (clr),
    .z        (z),
    .done     (done),
    .busy     (busy),
    .hit_cnt  (hit_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] zmask;   // bit i = z expected for evaluated bit i
    logic [7:0] cnt;     // hit_cnt expected in the done cycle
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  int n_chk  = 0;
  int n_pass = 0;
  int mdl_run = 0;
  int mdl_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
  endtask

  // Bit-level reference: clr_cyc = evaluation cycle (1..8) during which clr is high, 0 = none
  function automatic logic [7:0] model_word(input logic [7:0] d, input int clr_cyc);
    logic [7:0] m;
    logic       h;
    m = '0;
    for (int k = 1; k <= WORD_W; k++) begin
      h = 1'b0;
      if (k == clr_cyc) begin
        mdl_run = 0;
        mdl_cnt = 0;
      end else begin
        if (d[WORD_W-k]) mdl_run = (mdl_run < RUN_LEN) ? mdl_run + 1 : RUN_LEN;
        else             mdl_run = 0;
        h = (mdl_run == RUN_LEN);
`ifdef RUN_RESTART_EN
        if (h) mdl_run = 0;
`endif
        if (h && mdl_cnt < 255) mdl_cnt++;
      end
      m[WORD_W-k] = h;
    end
    return m;
  endfunction

  // Monitor: cycle 1 is the first busy cycle; z for bit i appears in cycle 9-i
  bit         mon_act = 1'b0;
  int         mon_cyc = 0;
  logic [7:0] mon_mask;
  always @(negedge clk) begin
    if (!rst) begin
      mon_act = 1'b0;
    end else if (!mon_act) begin
      if (busy) begin
        mon_act  = 1'b1;
        mon_cyc  = 1;
        mon_mask = '0;
      end
    end else begin
      mon_cyc++;
      if (mon_cyc >= 2 && mon_cyc <= WORD_W + 1) mon_mask[WORD_W + 1 - mon_cyc] = z;
      if (done) begin
        check_eq("done_latency", mon_cyc, WORD_W + 1);
        check_eq("busy_in_done", busy, 1'b0);
        if (sb_q.size() == 0) begin
          check_eq("sb_underflow", 1, 0);
        end else begin
          mon_e = sb_q.pop_front();
          check_eq("z_pattern", mon_mask, mon_e.zmask);
          check_eq("hit_cnt_word", hit_cnt, mon_e.cnt);
        end
        mon_act = 1'b0;
      end else if (mon_cyc > WORD_W + 4) begin
        check_eq("done_timeout", 0, 1);
        mon_act = 1'b0;
      end
    end
  end

  task automatic wait_ready();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = in_ready;
    end
    if (!ok) check_eq("ready_timeout", 0, 1);
  endtask

  task automatic wait_done();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      ok = done;
    end
    if (!ok) check_eq("wait_done_timeout", 0, 1);
  endtask

  task automatic send_word(input logic [7:0] d, input int clr_cyc);
    exp_t e;
    wait_ready();
    in_valid = 1'b1;
    in_data  = d;
    e.zmask  = model_word(d, clr_cyc);
    e.cnt    = 8'(mdl_cnt);
    sb_q.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'($urandom);   // must not matter after the handshake
    if (clr_cyc > 0) begin
      repeat (clr_cyc - 1) @(posedge clk);
      #1 clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
    end
  endtask

  task automatic pulse_clr();
    wait_ready();
    clr = 1'b1;
    @(posedge clk); #1 clr = 1'b0;
    mdl_run = 0;
    mdl_cnt = 0;
    @(negedge clk);
    check_eq("clr_hit_cnt", hit_cnt, 8'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    clr      = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", in_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_z", z, 1'b0);
    check_eq("rst_hit_cnt", hit_cnt, 8'd0);
    rst = 1'b1;

    // Single run of four at the top of the word
    send_word(8'hF0, 0);
    wait_done();
    check_eq("F0_hit_cnt", hit_cnt, 8'd1);

    // All ones: overlapping vs restart behaviour
    send_word(8'hFF, 0);
    wait_done();
    check_eq("FF_hit_cnt", hit_cnt, 8'(1 + FF_HITS));

    // Run spanning a word boundary, sent back to back, then no run
    pulse_clr();
    send_word(8'h03, 0);
    send_word(8'hC0, 0);
    wait_done();
    check_eq("span_hit_cnt", hit_cnt, 8'd1);
    send_word(8'hEE, 0);
    wait_done();
    check_eq("EE_hit_cnt", hit_cnt, 8'd1);

    // Clear inside a word: no abort, bit in the clear cycle neither hits nor counts
    send_word(8'hFF, 4);
    send_word(8'hFF, 6);
    wait_done();

    // Reset in the middle of a word
    wait_ready();
    in_valid = 1'b1;
    in_data  = 8'hFF;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("mid_rst_in_ready", in_ready, 1'b1);
    check_eq("mid_rst_busy", busy, 1'b0);
    check_eq("mid_rst_done", done, 1'b0);
    check_eq("mid_rst_z", z, 1'b0);
    check_eq("mid_rst_hit_cnt", hit_cnt, 8'd0);
    @(negedge clk);
    @(negedge clk);
    rst     = 1'b1;
    mdl_run = 0;
    mdl_cnt = 0;
    send_word(8'h0F, 0);
    wait_done();
    check_eq("0F_hit_cnt", hit_cnt, 8'd1);

    // Random words, back to back
    for (int i = 0; i < 10; i++) send_word(8'($urandom), 0);
    wait_done();

    // Saturation of the hit tally
    pulse_clr();
    for (int i = 0; i < 52; i++) send_word(8'hFF, 0);
    wait_done();
`ifndef RUN_RESTART_EN
    check_eq("sat_hit_cnt", hit_cnt, 8'd255);
`else
    check_eq("sat_hit_cnt", hit_cnt, 8'd104);
`endif
    pulse_clr();

    repeat (4) @(negedge clk);
    check_eq("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
